// File: rtl/fcb_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fcb_skid_pipe
// Brief    : Full-throughput valid/ready pipeline built from cascaded skid
//            stages, with registered handshakes and an occupancy counter.
// Revision : 1.0
// ============================================================================
module fcb_skid_pipe #(
    parameter int W        = 8,
    parameter int N_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              up_vld,
    output logic                              up_rdy,
    input  logic [W-1:0]                      up_data,
    output logic                              down_vld,
    input  logic                              down_rdy,
    output logic [W-1:0]                      down_data,
    output logic [$clog2(2*N_STAGES+1)-1:0]   count,
    output logic                              idle
);

    localparam int CW = $clog2(2*N_STAGES+1);

    logic [N_STAGES-1:0] stg_vld;
    logic [N_STAGES-1:0] stg_rdy;
    logic [W-1:0]        stg_data [N_STAGES];

    logic                up_xfer;
    logic                down_xfer;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;

    genvar k;
    generate
        for (k = 0; k < N_STAGES; k++) begin : g_stage
            logic         in_vld;
            logic [W-1:0] in_data;
            logic         out_rdy;
            logic         in_xfer;
            logic         out_take;

            logic         main_vld_q;
            logic         main_vld_d;
            logic [W-1:0] main_data_q;
            logic         skid_vld_q;
            logic         skid_vld_d;
            logic [W-1:0] skid_data_q;

            logic         main_ld;
            logic         main_from_skid;
            logic         skid_ld;

            if (k == 0) begin : g_first
                assign in_vld  = up_vld;
                assign in_data = up_data;
            end else begin : g_chain
                assign in_vld  = stg_vld[k-1];
                assign in_data = stg_data[k-1];
            end

            if (k == N_STAGES-1) begin : g_last
                assign out_rdy = down_rdy;
            end else begin : g_inner
                assign out_rdy = stg_rdy[k+1];
            end

            // Ready toward the previous stage is purely the registered skid flag.
            assign in_xfer  = in_vld & ~skid_vld_q;
            assign out_take = main_vld_q & out_rdy;

            always_comb begin
                main_vld_d     = main_vld_q;
                skid_vld_d     = skid_vld_q;
                main_ld        = 1'b0;
                main_from_skid = 1'b0;
                skid_ld        = 1'b0;
                if (!main_vld_q || out_take) begin
                    if (skid_vld_q) begin
                        main_vld_d     = 1'b1;
                        skid_vld_d     = 1'b0;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end else if (in_xfer) begin
                        main_vld_d = 1'b1;
                        main_ld    = 1'b1;
                    end else begin
                        main_vld_d = 1'b0;
                    end
                end else if (in_xfer) begin
                    skid_vld_d = 1'b1;
                    skid_ld    = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_vld_q <= 1'b0;
                    skid_vld_q <= 1'b0;
                end else begin
                    main_vld_q <= main_vld_d;
                    skid_vld_q <= skid_vld_d;
                end
            end

            always_ff @(posedge clk) begin
                if (main_ld) begin
                    main_data_q <= main_from_skid ? skid_data_q : in_data;
                end
                if (skid_ld) begin
                    skid_data_q <= in_data;
                end
            end

            assign stg_vld[k]  = main_vld_q;
            assign stg_data[k] = main_data_q;
            assign stg_rdy[k]  = ~skid_vld_q;
        end
    endgenerate

    assign up_rdy    = stg_rdy[0];
    assign down_vld  = stg_vld[N_STAGES-1];
    assign down_data = stg_data[N_STAGES-1];

    assign up_xfer   = up_vld & up_rdy;
    assign down_xfer = down_vld & down_rdy;

    always_comb begin
        count_d = count_q;
        case ({up_xfer, down_xfer})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign idle  = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_fcb_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fcb_skid_pipe
// Brief    : Scoreboard bench for fcb_skid_pipe at depths 1, 2 and 8.
// Revision : 1.0
// ============================================================================
module tb_fcb_skid_pipe;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         up_vld   = 1'b0;
    logic         down_rdy = 1'b0;
    logic [W-1:0] up_data  = '0;

    logic [2:0]   up_rdy_a;
    logic [2:0]   down_vld_a;
    logic [2:0]   idle_a;
    logic [W-1:0] down_data_a [3];
    logic [7:0]   count_a     [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    generate
        for (genvar k = 0; k < 3; k++) begin : g_dut
            localparam int NS = (k == 0) ? 1 : ((k == 1) ? 2 : 8);
            localparam int CW = $clog2(2*NS+1);

            logic [CW-1:0] cnt;
            logic          urdy;
            logic          dvld;
            logic          idl;
            logic [W-1:0]  ddat;

            fcb_skid_pipe #(.W(W), .N_STAGES(NS)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .up_vld    (up_vld),
                .up_rdy    (urdy),
                .up_data   (up_data),
                .down_vld  (dvld),
                .down_rdy  (down_rdy),
                .down_data (ddat),
                .count     (cnt),
                .idle      (idl)
            );

            assign up_rdy_a[k]    = urdy;
            assign down_vld_a[k]  = dvld;
            assign idle_a[k]      = idl;
            assign down_data_a[k] = ddat;
            assign count_a[k]     = 8'(cnt);

            logic [W-1:0] q [$];
            bit           prev_stall = 1'b0;
            logic [W-1:0] prev_data  = '0;
            logic [W-1:0] exp_w;

            // Reference FIFO: push on accepted input, pop on accepted output.
            always @(negedge clk) begin
                if (!rst_n) begin
                    q.delete();
                    prev_stall = 1'b0;
                end else begin
                    chk($sformatf("count_depth[n=%0d]", NS), 32'(cnt), 32'(q.size()));
                    chk($sformatf("idle[n=%0d]", NS), 32'(idl), 32'(q.size() == 0));
                    chk($sformatf("capacity[n=%0d]", NS), 32'(q.size() <= 2*NS), 32'd1);
                    if (prev_stall) begin
                        chk($sformatf("hold_vld[n=%0d]", NS), 32'(dvld), 32'd1);
                        chk($sformatf("hold_data[n=%0d]", NS), 32'(ddat), 32'(prev_data));
                    end
                    if (dvld && down_rdy) begin
                        if (q.size() == 0) begin
                            chk($sformatf("pop_empty[n=%0d]", NS), 32'(q.size()), 32'd1);
                        end else begin
                            exp_w = q.pop_front();
                            chk($sformatf("sb_data[n=%0d]", NS), 32'(ddat), 32'(exp_w));
                        end
                    end
                    if (up_vld && urdy) q.push_back(up_data);
                    prev_stall = dvld && !down_rdy;
                    prev_data  = ddat;
                end
            end
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        up_vld   = 1'b0;
        down_rdy = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        int  w;
        int  acc;
        int  guard;
        int  maxc;
        bit  take;

        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_up_rdy", 32'(up_rdy_a[k]), 32'd1);
            chk("rst_down_vld", 32'(down_vld_a[k]), 32'd0);
            chk("rst_count", 32'(count_a[k]), 32'd0);
            chk("rst_idle", 32'(idle_a[k]), 32'd1);
        end
        step();
        rst_n = 1'b1;

        // Single word latency through the two-stage pipe.
        up_vld = 1'b1; up_data = 8'hA5; down_rdy = 1'b1;
        step();
        up_vld = 1'b0;
        chk("lat_cnt0", 32'(count_a[1]), 32'd1);
        chk("lat_vld0", 32'(down_vld_a[1]), 32'd0);
        step();
        chk("lat_vld1", 32'(down_vld_a[1]), 32'd1);
        chk("lat_data1", 32'(down_data_a[1]), 32'hA5);
        chk("lat_cnt1", 32'(count_a[1]), 32'd1);
        step();
        chk("lat_vld2", 32'(down_vld_a[1]), 32'd0);
        chk("lat_cnt2", 32'(count_a[1]), 32'd0);
        chk("lat_idle2", 32'(idle_a[1]), 32'd1);
        drain(20);

        // Back-to-back streaming.
        down_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            up_vld = 1'b1; up_data = 8'(i);
            chk("stream_up_rdy", 32'(up_rdy_a[1]), 32'd1);
            step();
            if (i >= 1) begin
                chk("stream_vld", 32'(down_vld_a[1]), 32'd1);
                chk("stream_data", 32'(down_data_a[1]), 32'(i-1));
            end
        end
        up_vld = 1'b0;
        step();
        chk("stream_last_vld", 32'(down_vld_a[1]), 32'd1);
        chk("stream_last_data", 32'(down_data_a[1]), 32'd99);
        drain(20);

        // Full backpressure: only four words fit in two stages.
        down_rdy = 1'b0; w = 1; acc = 0;
        repeat (6) begin
            up_vld = 1'b1; up_data = 8'(w);
            take = up_rdy_a[1];
            step();
            if (take) begin acc++; w++; end
        end
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_up_rdy", 32'(up_rdy_a[1]), 32'd0);
        chk("bp_count", 32'(count_a[1]), 32'd4);
        chk("bp_down_vld", 32'(down_vld_a[1]), 32'd1);
        chk("bp_down_data", 32'(down_data_a[1]), 32'd1);
        repeat (2) step();
        chk("bp_hold_data", 32'(down_data_a[1]), 32'd1);
        down_rdy = 1'b1;
        chk("bp_rdy_not_yet", 32'(up_rdy_a[1]), 32'd0);
        guard = 0;
        while (w <= 6 && guard < 20) begin
            up_vld = 1'b1; up_data = 8'(w);
            take = up_rdy_a[1];
            step();
            if (take) w++;
            guard++;
        end
        chk("bp_refill", 32'(w), 32'd7);
        drain(20);
        chk("bp_idle_end", 32'(idle_a[1]), 32'd1);

        // One-cycle stall every third cycle.
        w = 0; maxc = 0; guard = 0;
        while (w < 60 && guard < 200) begin
            down_rdy = (guard % 3) != 2;
            up_vld = 1'b1; up_data = 8'(w);
            take = up_rdy_a[1];
            step();
            if (take) w++;
            if (int'(count_a[1]) > maxc) maxc = int'(count_a[1]);
            guard++;
        end
        chk("stall_all_sent", 32'(w), 32'd60);
        chk("stall_max_count", 32'(maxc <= 4), 32'd1);
        drain(20);

        // Reset with three words in flight.
        down_rdy = 1'b0;
        up_vld = 1'b1; up_data = 8'h11; step();
        up_data = 8'h22; step();
        up_data = 8'h33; step();
        up_vld = 1'b0;
        chk("mid_count3", 32'(count_a[1]), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(down_vld_a[1]), 32'd0);
        chk("mid_rst_count", 32'(count_a[1]), 32'd0);
        chk("mid_rst_up_rdy", 32'(up_rdy_a[1]), 32'd1);
        chk("mid_rst_idle", 32'(idle_a[1]), 32'd1);
        step();
        rst_n = 1'b1;
        down_rdy = 1'b1;
        repeat (4) begin
            step();
            chk("mid_no_stale", 32'(down_vld_a[1]), 32'd0);
        end

        // Random traffic, first downstream-heavy then backpressure-heavy.
        for (int c = 0; c < 10000; c++) begin
            up_vld   = ($urandom % 4) != 0;
            down_rdy = (c < 5000) ? (($urandom % 3) != 0) : (($urandom % 3) == 0);
            up_data  = 8'($urandom);
            step();
        end
        drain(40);
        for (int k = 0; k < 3; k++) begin
            chk("final_idle", 32'(idle_a[k]), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
